// File: rtl/sign_mag_conv_serial_pkg.sv
// Shared constants and helpers for the serial two's-complement / sign-magnitude converter.
package sign_mag_pkg;

   // Conversion direction, sampled together with the source word
   localparam logic MODE_2C_TO_SM = 1'b0;
   localparam logic MODE_SM_TO_2C = 1'b1;

   // Controller states, 2-bit legacy-compatible encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Number of chunk cycles needed to cover a magnitude of 'a' bits, 'b' bits at a time
   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/sign_mag_conv_serial_slice.sv
// One chunk of the conditional-invert-plus-increment ripple: each bit is a half
// adder fed by a_i ^ sign. Masked-off bits output 0 and pass the carry through untouched.
module cond_inc_slice #(
   parameter int unsigned CHUNK = 1
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic             sign_i,
   input  logic             carry_i,
   input  logic [CHUNK-1:0] mask_i,
   output logic [CHUNK-1:0] out_o,
   output logic             carry_o
);

   logic [CHUNK:0] c;

   assign c[0] = carry_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic t;
      assign t          = a_i[i] ^ sign_i;
      // half adder: sum = t ^ c, carry = t & c
      assign out_o[i]   = mask_i[i] & (t ^ c[i]);
      assign c[i+1]     = mask_i[i] ? (t & c[i]) : c[i];
   end

   assign carry_o = c[CHUNK];

endmodule

// File: rtl/sign_mag_conv_serial.sv
// Multi-cycle WIDTH-bit converter between two's complement and sign-magnitude,
// CHUNK magnitude bits per clock, with valid/ready handshakes on both sides.
module sign_mag_conv_serial
   import sign_mag_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             ovr,
   output logic             negz,
   output logic             busy
);

   localparam int unsigned M  = WIDTH - 1;           // magnitude bits
   localparam int unsigned N  = ceil_div(M, CHUNK);  // RUN cycles
   localparam int unsigned P  = N * CHUNK;           // padded magnitude register
   localparam int unsigned CW = $clog2(N + 1);

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic             sign_q, sign_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [P-1:0]     mag_q, mag_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovr_q, ovr_d;
   logic             negz_q, negz_d;

   logic [CHUNK-1:0]   mask_w;
   logic [CHUNK-1:0]   slice_out_w;
   logic               slice_carry_w;
   logic [P+CHUNK-1:0] rot_w;
   logic [P-1:0]       mag_next_w;
   logic               last_w;

   // Valid-bit mask: slice bits past the top magnitude bit are ignored
   always_comb begin
      mask_w = '0;
      for (int unsigned j = 0; j < CHUNK; j++) begin
         mask_w[j] = ((32'(cnt_q) * CHUNK) + j) < M;
      end
   end

   cond_inc_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_i     (mag_q[CHUNK-1:0]),
      .sign_i  (sign_q),
      .carry_i (carry_q),
      .mask_i  (mask_w),
      .out_o   (slice_out_w),
      .carry_o (slice_carry_w)
   );

   // Results enter at the top while the source shifts out of the bottom; after N
   // chunk rotations the register holds the converted magnitude in place.
   assign rot_w      = {slice_out_w, mag_q};
   assign mag_next_w = rot_w[P+CHUNK-1:CHUNK];
   assign last_w     = (cnt_q == CW'(N - 1));

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sign_d  = sign_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      dout_d  = dout_q;
      ovr_d   = ovr_q;
      negz_d  = negz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               mode_d       = mode;
               sign_d       = din[WIDTH-1];
               carry_d      = din[WIDTH-1];
               cnt_d        = '0;
               mag_d        = '0;
               mag_d[M-1:0] = din[M-1:0];
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            mag_d   = mag_next_w;
            carry_d = slice_carry_w;
            cnt_d   = cnt_q + CW'(1);
            if (last_w) begin
               state_d = ST_DONE;
               if (mode_q == MODE_2C_TO_SM) begin
                  dout_d = {sign_q, mag_next_w[M-1:0]};
                  ovr_d  = sign_q & slice_carry_w;
                  negz_d = 1'b0;
               end else begin
                  dout_d = {sign_q & ~slice_carry_w, mag_next_w[M-1:0]};
                  ovr_d  = 1'b0;
                  negz_d = sign_q & slice_carry_w;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         sign_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         mag_q   <= '0;
         dout_q  <= '0;
         ovr_q   <= 1'b0;
         negz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sign_q  <= sign_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         dout_q  <= dout_d;
         ovr_q   <= ovr_d;
         negz_q  <= negz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) & ~rst;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) | (state_q == ST_DONE);
   assign dout      = dout_q;
   assign ovr       = ovr_q;
   assign negz      = negz_q;

endmodule

// File: tb/tb_sign_mag_conv_serial.sv
// Self-checking bench for sign_mag_conv_serial: three instances
// (8/1, 8/7, 16/3) checked against an arithmetic reference model.
module tb_sign_mag_conv_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [15:0] din;
   logic        out_ready;
   logic        iv_a, iv_b, iv_c;

   logic        ir_a, ov_a, ovr_a, negz_a, busy_a;
   logic [7:0]  dout_a;
   logic        ir_b, ov_b, ovr_b, negz_b, busy_b;
   logic [7:0]  dout_b;
   logic        ir_c, ov_c, ovr_c, negz_c, busy_c;
   logic [15:0] dout_c;

   int          sel;
   logic        r_ir, r_ov, r_ovr, r_negz, r_busy;
   logic [15:0] r_dout;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sign_mag_conv_serial #(.WIDTH(8), .CHUNK(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .mode(mode), .din(din[7:0]),
      .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a), .ovr(ovr_a), .negz(negz_a), .busy(busy_a));

   sign_mag_conv_serial #(.WIDTH(8), .CHUNK(7)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .mode(mode), .din(din[7:0]),
      .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b), .ovr(ovr_b), .negz(negz_b), .busy(busy_b));

   sign_mag_conv_serial #(.WIDTH(16), .CHUNK(3)) u_c (
      .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .mode(mode), .din(din),
      .out_valid(ov_c), .out_ready(out_ready), .dout(dout_c), .ovr(ovr_c), .negz(negz_c), .busy(busy_c));

   // View of the currently selected instance
   always_comb begin
      r_ir = 1'b0; r_ov = 1'b0; r_ovr = 1'b0; r_negz = 1'b0; r_busy = 1'b0; r_dout = '0;
      case (sel)
         0: begin r_ir = ir_a; r_ov = ov_a; r_ovr = ovr_a; r_negz = negz_a; r_busy = busy_a; r_dout = {8'h00, dout_a}; end
         1: begin r_ir = ir_b; r_ov = ov_b; r_ovr = ovr_b; r_negz = negz_b; r_busy = busy_b; r_dout = {8'h00, dout_b}; end
         default: begin r_ir = ir_c; r_ov = ov_c; r_ovr = ovr_c; r_negz = negz_c; r_busy = busy_c; r_dout = dout_c; end
      endcase
   end

   function automatic int width_of(input int s);
      return (s == 2) ? 16 : 8;
   endfunction

   function automatic int chunk_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 7 : 3;
   endfunction

   // Edges from accept (inclusive) until out_valid: ceil((W-1)/C) + 1
   function automatic int exp_edges(input int s);
      return (width_of(s) - 1 + chunk_of(s) - 1) / chunk_of(s) + 1;
   endfunction

   // Reference: numeric value semantics of both encodings
   function automatic void ref_conv(input int w, input bit m, input logic [15:0] x_in,
                                    output logic [15:0] d, output bit o, output bit nz);
      longint unsigned full, half, x, v;
      full = 64'd1 << w;
      half = 64'd1 << (w - 1);
      x    = 64'(x_in) & (full - 1);
      o    = 1'b0;
      nz   = 1'b0;
      if (x < half) begin
         d = 16'(x);
      end else if (m == 1'b0) begin
         v = full - x;                 // magnitude of the negative value
         if (v == half) begin
            o = 1'b1;
            d = 16'(x);
         end else begin
            d = 16'(half + v);
         end
      end else begin
         v = x - half;                 // magnitude field
         if (v == 0) begin
            nz = 1'b1;
            d  = 16'h0000;
         end else begin
            d  = 16'((full - v) & (full - 1));
         end
      end
   endfunction

   task automatic set_iv(input bit v);
      iv_a = v && (sel == 0);
      iv_b = v && (sel == 1);
      iv_c = v && (sel == 2);
   endtask

   // Offer a word, wait for acceptance, then wait for out_valid; leaves the DUT in DONE at a negedge
   task automatic start_and_wait(input int s, input bit m, input logic [15:0] d,
                                 output int edges, output bit tmo);
      int k;
      sel   = s;
      tmo   = 1'b0;
      edges = 0;
      @(negedge clk);
      mode      = m;
      din       = d;
      out_ready = 1'b0;
      set_iv(1'b1);
      for (k = 0; k < 50 && !r_ir; k++) @(negedge clk);
      if (!r_ir) begin
         tmo = 1'b1;
         set_iv(1'b0);
         return;
      end
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      set_iv(1'b0);
      mode = 1'($urandom);
      din  = 16'($urandom);
      for (k = 0; k < 100 && !r_ov; k++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (!r_ov) tmo = 1'b1;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
      mode = 1'b0; din = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if ({r_ir, r_ov, r_busy, r_ovr, r_negz, r_dout} !== 21'd0)
            $display("FAIL reset_state inst=%0d: ir=%b ov=%b busy=%b ovr=%b negz=%b dout=%h, required all 0",
                     s, r_ir, r_ov, r_busy, r_ovr, r_negz, r_dout);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if (r_ir !== 1'b1) $display("FAIL reset_release_ready inst=%0d: in_ready=%b, required 1", s, r_ir);
         else n_pass++;
      end
   endtask

   typedef struct {
      int          s;
      bit          m;
      logic [15:0] d;
      logic [15:0] e;
      bit          o;
      bit          nz;
   } vec_t;

   task automatic test_directed();
      vec_t tbl[8];
      int   edges;
      bit   tmo;
      tbl[0] = '{0, 1'b0, 16'h00FB, 16'h0085, 1'b0, 1'b0};
      tbl[1] = '{0, 1'b0, 16'h0080, 16'h0080, 1'b1, 1'b0};
      tbl[2] = '{0, 1'b0, 16'h0035, 16'h0035, 1'b0, 1'b0};
      tbl[3] = '{0, 1'b1, 16'h0085, 16'h00FB, 1'b0, 1'b0};
      tbl[4] = '{0, 1'b1, 16'h0080, 16'h0000, 1'b0, 1'b1};
      tbl[5] = '{2, 1'b0, 16'h8001, 16'hFFFF, 1'b0, 1'b0};
      tbl[6] = '{1, 1'b0, 16'h00FB, 16'h0085, 1'b0, 1'b0};
      tbl[7] = '{2, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1};
      foreach (tbl[i]) begin
         start_and_wait(tbl[i].s, tbl[i].m, tbl[i].d, edges, tmo);
         n_checks++;
         if (tmo || edges != exp_edges(tbl[i].s))
            $display("FAIL directed_latency #%0d: edges=%0d timeout=%b, required %0d", i, edges, tmo, exp_edges(tbl[i].s));
         else n_pass++;
         n_checks++;
         if (r_dout !== tbl[i].e || r_ovr !== tbl[i].o || r_negz !== tbl[i].nz)
            $display("FAIL directed_result #%0d din=%h mode=%b: dout=%h ovr=%b negz=%b, required %h %b %b",
                     i, tbl[i].d, tbl[i].m, r_dout, r_ovr, r_negz, tbl[i].e, tbl[i].o, tbl[i].nz);
         else n_pass++;
         release_result();
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] e;
      bit          o, nz, tmo;
      int          edges;
      ref_conv(8, 1'b0, 16'h00C3, e, o, nz);
      start_and_wait(0, 1'b0, 16'h00C3, edges, tmo);
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (tmo || r_ov !== 1'b1 || r_ir !== 1'b0 || r_busy !== 1'b1 || r_dout !== e || r_ovr !== o || r_negz !== nz)
            $display("FAIL backpressure_hold cycle=%0d: ov=%b ir=%b busy=%b dout=%h ovr=%b negz=%b, required 1 0 1 %h %b %b",
                     c, r_ov, r_ir, r_busy, r_dout, r_ovr, r_negz, e, o, nz);
         else n_pass++;
         @(negedge clk);
      end
      release_result();
      n_checks++;
      if (r_ir !== 1'b1 || r_ov !== 1'b0 || r_busy !== 1'b0)
         $display("FAIL backpressure_release: ir=%b ov=%b busy=%b, required 1 0 0", r_ir, r_ov, r_busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int edges;
      bit tmo;
      int k;
      sel = 0;
      @(negedge clk);
      mode = 1'b1; din = 16'h00AA;
      set_iv(1'b1);
      for (k = 0; k < 50 && !r_ir; k++) @(negedge clk);
      @(posedge clk);                    // accept, cnt=0
      @(negedge clk);
      set_iv(1'b0);
      repeat (3) @(posedge clk);         // cnt=3, still in RUN
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (r_ov !== 1'b0 || r_busy !== 1'b0 || r_ir !== 1'b0 || r_dout !== 16'h0000 || r_ovr !== 1'b0 || r_negz !== 1'b0)
         $display("FAIL reset_mid_run: ov=%b busy=%b ir=%b dout=%h ovr=%b negz=%b, required all 0",
                  r_ov, r_busy, r_ir, r_dout, r_ovr, r_negz);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      start_and_wait(0, 1'b0, 16'h00FF, edges, tmo);
      n_checks++;
      if (tmo || edges != 8 || r_dout !== 16'h0081 || r_ovr !== 1'b0 || r_negz !== 1'b0)
         $display("FAIL reset_recover: dout=%h ovr=%b negz=%b edges=%0d timeout=%b, required 0081 0 0 8 0",
                  r_dout, r_ovr, r_negz, edges, tmo);
      else n_pass++;
      release_result();
   endtask

   task automatic test_exhaustive();
      logic [15:0] e;
      bit          o, nz, tmo;
      int          edges;
      for (int s = 0; s < 2; s++) begin
         for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 256; x++) begin
               ref_conv(8, 1'(m), 16'(x), e, o, nz);
               start_and_wait(s, 1'(m), 16'(x), edges, tmo);
               n_checks++;
               if (tmo || edges != exp_edges(s) || r_dout !== e || r_ovr !== o || r_negz !== nz)
                  $display("FAIL exhaustive inst=%0d mode=%0d din=%h: dout=%h ovr=%b negz=%b edges=%0d, required %h %b %b %0d",
                           s, m, x, r_dout, r_ovr, r_negz, edges, e, o, nz, exp_edges(s));
               else n_pass++;
               release_result();
            end
         end
      end
   endtask

   task automatic test_random_w16();
      logic [15:0] e, x;
      bit          o, nz, tmo, m;
      int          edges;
      for (int i = 0; i < 200; i++) begin
         x = 16'($urandom);
         if (i % 17 == 0) x = 16'h8000;
         if (i % 23 == 0) x = 16'hFFFF;
         m = 1'($urandom);
         ref_conv(16, m, x, e, o, nz);
         start_and_wait(2, m, x, edges, tmo);
         n_checks++;
         if (tmo || edges != exp_edges(2) || r_dout !== e || r_ovr !== o || r_negz !== nz)
            $display("FAIL random_w16 mode=%b din=%h: dout=%h ovr=%b negz=%b edges=%0d, required %h %b %b %0d",
                     m, x, r_dout, r_ovr, r_negz, edges, e, o, nz, exp_edges(2));
         else n_pass++;
         release_result();
      end
   endtask

   initial begin
      sel = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_exhaustive();
      test_random_w16();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
